// File: rtl/mini_src_pkg.sv
// Shared constants and types for the Mini SRC control sequencer.
//   - bus-source select codes driven onto reg_out_select
//   - instruction opcodes (ir[31:27])
//   - ALU operation encodings driven onto alu_op
//   - control-step state enum and decoded instruction class enum
package mini_src_pkg;

    // Bus source selects
    localparam logic [4:0] BUS_REG  = 5'b00000;
    localparam logic [4:0] BUS_PC   = 5'b10100;
    localparam logic [4:0] BUS_IR   = 5'b10101;
    localparam logic [4:0] BUS_MDR  = 5'b10110;
    localparam logic [4:0] BUS_ZLO  = 5'b10111;
    localparam logic [4:0] BUS_C    = 5'b11000;
    localparam logic [4:0] BUS_NONE = 5'b11111;

    // Opcodes
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HLT
    } state_e;

    typedef enum logic [2:0] {
        IC_ALU, IC_IMM, IC_LD, IC_ST, IC_NOP, IC_HALT, IC_ILLEGAL
    } iclass_e;

endpackage

// File: rtl/mini_src_control_unit_if.sv
// Control bundle between the Mini SRC sequencer and its datapath.
//   master: the control unit (reads ir/mem_ready/stop, drives strobes)
//   slave : the datapath and memory side
// Memory handshake: mem_read / mem_write is held high for as long as the
// request is outstanding; the access completes on the first rising edge
// where mem_ready is also high. mem_ready is meaningless at any other time.
interface mini_src_control_unit_if #(
    parameter int REG_AW = 4
) ();
    logic [31:0]       ir;
    logic              mem_ready;
    logic              stop;
    logic [4:0]        reg_out_select;
    logic [REG_AW-1:0] addr_out;
    logic [REG_AW-1:0] addr_in;
    logic              load;
    logic              pc_in;
    logic              inc_pc;
    logic              ir_in;
    logic              mar_in;
    logic              y_in;
    logic              z_in;
    logic              mdr_in;
    logic              mdr_rd;
    logic [1:0]        alu_op;
    logic              mem_read;
    logic              mem_write;
    logic              run;
    logic              illegal_op;
    logic              fault;

    modport master (
        input  ir, mem_ready, stop,
        output reg_out_select, addr_out, addr_in, load, pc_in, inc_pc,
               ir_in, mar_in, y_in, z_in, mdr_in, mdr_rd, alu_op,
               mem_read, mem_write, run, illegal_op, fault
    );

    modport slave (
        output ir, mem_ready, stop,
        input  reg_out_select, addr_out, addr_in, load, pc_in, inc_pc,
               ir_in, mar_in, y_in, z_in, mdr_in, mdr_rd, alu_op,
               mem_read, mem_write, run, illegal_op, fault
    );
endinterface

// File: rtl/mini_src_decoder.sv
// Combinational opcode decoder.
//   opcode : ir[31:27]
//   iclass : instruction class (ALU / IMM / LD / ST / NOP / HALT / ILLEGAL)
//   alu_op : ALU operation for register-register ALU instructions, ADD otherwise
module mini_src_decoder
    import mini_src_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_e    iclass,
    output logic [1:0] alu_op
);

    always_comb begin
        iclass = IC_ILLEGAL;
        alu_op = ALU_ADD;
        case (opcode)
            OP_LD:   iclass = IC_LD;
            OP_ST:   iclass = IC_ST;
            OP_ADD:  iclass = IC_ALU;
            OP_SUB:  begin iclass = IC_ALU; alu_op = ALU_SUB; end
            OP_AND:  begin iclass = IC_ALU; alu_op = ALU_AND; end
            OP_OR:   begin iclass = IC_ALU; alu_op = ALU_OR;  end
            OP_ADDI: iclass = IC_IMM;
            OP_NOP:  iclass = IC_NOP;
            OP_HALT: iclass = IC_HALT;
            default: iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired control sequencer for the Mini SRC datapath.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : control bundle (master side), see mini_src_control_unit_if
//   dbg_state  : current control step, for observation only
// One control step per clock. Strobes are decoded from the registered step
// (plus the latched IR, which is stable from T3 onwards). Reset and stop
// gate the decode directly so that an asserted reset drops any request in
// the same cycle and a stop in T0 suppresses the fetch strobes at once.
module mini_src_control_unit
    import mini_src_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int REG_AW   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    mini_src_control_unit_if.master bus,
    output state_e                  dbg_state
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    state_e        state;
    logic [CW-1:0] wait_cnt;
    logic          fault_q;
    iclass_e       iclass;
    logic [1:0]    dec_alu_op;
    logic          in_wait;
    logic          timed_out;

    mini_src_decoder u_decoder (
        .opcode (bus.ir[31:27]),
        .iclass (iclass),
        .alu_op (dec_alu_op)
    );

    // States in which the FSM is waiting on mem_ready.
    assign in_wait = (state == T1)
                  || (state == T6 && iclass == IC_LD)
                  || (state == T7 && iclass == IC_ST);

    // wait_cnt holds the number of wait cycles already spent; this cycle
    // would be number wait_cnt+1.
    assign timed_out = in_wait && !bus.mem_ready && (MAX_WAIT != 0)
                    && (int'(wait_cnt) + 1 == MAX_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= T0;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else if (in_wait && !bus.mem_ready) begin
            if (timed_out) begin
                state    <= HLT;
                fault_q  <= 1'b1;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end else begin
            // Any advance clears the counter, so every wait state starts at 0.
            wait_cnt <= '0;
            case (state)
                T0: if (!bus.stop) state <= T1;
                T1: state <= T2;
                T2: state <= T3;
                T3: begin
                    case (iclass)
                        IC_ALU, IC_IMM, IC_LD, IC_ST: state <= T4;
                        IC_HALT: state <= HLT;
                        default: state <= T0;
                    endcase
                end
                T4: state <= T5;
                T5: state <= (iclass == IC_LD || iclass == IC_ST) ? T6 : T0;
                T6: state <= T7;
                T7: state <= T0;
                HLT: state <= HLT;
                default: state <= T0;
            endcase
        end
    end

    always_comb begin
        bus.reg_out_select = BUS_NONE;
        bus.addr_out       = '0;
        bus.addr_in        = '0;
        bus.load           = 1'b0;
        bus.pc_in          = 1'b0;
        bus.inc_pc         = 1'b0;
        bus.ir_in          = 1'b0;
        bus.mar_in         = 1'b0;
        bus.y_in           = 1'b0;
        bus.z_in           = 1'b0;
        bus.mdr_in         = 1'b0;
        bus.mdr_rd         = 1'b0;
        bus.alu_op         = ALU_ADD;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.illegal_op     = 1'b0;
        if (!reset) begin
            case (state)
                T0: begin
                    if (!bus.stop) begin
                        bus.reg_out_select = BUS_PC;
                        bus.mar_in         = 1'b1;
                        bus.inc_pc         = 1'b1;
                    end
                end
                T1: begin
                    bus.mem_read = 1'b1;
                    bus.mdr_rd   = 1'b1;
                    bus.mdr_in   = 1'b1;
                end
                T2: begin
                    bus.reg_out_select = BUS_MDR;
                    bus.ir_in          = 1'b1;
                end
                T3: begin
                    case (iclass)
                        IC_ALU, IC_IMM, IC_LD, IC_ST: begin
                            bus.reg_out_select = BUS_REG;
                            bus.addr_out       = REG_AW'(bus.ir[22:19]);
                            bus.y_in           = 1'b1;
                        end
                        IC_ILLEGAL: bus.illegal_op = 1'b1;
                        default: ;
                    endcase
                end
                T4: begin
                    bus.z_in = 1'b1;
                    if (iclass == IC_ALU) begin
                        bus.reg_out_select = BUS_REG;
                        bus.addr_out       = REG_AW'(bus.ir[18:15]);
                        bus.alu_op         = dec_alu_op;
                    end else begin
                        bus.reg_out_select = BUS_C;
                    end
                end
                T5: begin
                    bus.reg_out_select = BUS_ZLO;
                    if (iclass == IC_LD || iclass == IC_ST) begin
                        bus.mar_in = 1'b1;
                    end else begin
                        bus.load    = 1'b1;
                        bus.addr_in = REG_AW'(bus.ir[26:23]);
                    end
                end
                T6: begin
                    bus.mdr_in = 1'b1;
                    if (iclass == IC_LD) begin
                        bus.mem_read = 1'b1;
                        bus.mdr_rd   = 1'b1;
                    end else begin
                        bus.reg_out_select = BUS_REG;
                        bus.addr_out       = REG_AW'(bus.ir[26:23]);
                    end
                end
                T7: begin
                    if (iclass == IC_LD) begin
                        bus.reg_out_select = BUS_MDR;
                        bus.load           = 1'b1;
                        bus.addr_in        = REG_AW'(bus.ir[26:23]);
                    end else begin
                        bus.mem_write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.run   = reset || (state != HLT);
    assign bus.fault = !reset && fault_q;
    assign dbg_state = state;

endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
- Hardwired control sequencer for the Mini SRC datapath: bus, register file, PC, IR, MAR/MDR, Y/Z and ALU.
- One control step per clock, Moore outputs.
- Fetches, decodes and executes a load/store/ALU subset by driving bus-select, register-load and memory-handshake strobes.
- Sits in cpu_top beside the bus mux; replaces the hand-driven load/select stimulus.

Parameters:
- MAX_WAIT, 15: memory wait cycles tolerated per access before a fault. 0 disables the timeout.
- REG_AW, 4: register-file address width.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: synchronous, active-high.
- ir, in, 32: current IR contents. opcode = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15], C = ir[18:0].
- mem_ready, in, 1: memory completed the current read/write.
- stop, in, 1: pause before the next fetch.
- reg_out_select, out, 5: bus source select.
- addr_out, out, REG_AW: register-file read address.
- addr_in, out, REG_AW: register-file write address.
- load, out, 1: register-file write enable.
- pc_in, inc_pc, ir_in, mar_in, y_in, z_in, out, 1 each: register load strobes.
- mdr_in, out, 1: MDR load strobe.
- mdr_rd, out, 1: MDR source select. 1 = memory data, 0 = bus.
- alu_op, out, 2: 00 ADD, 01 SUB, 10 AND, 11 OR.
- mem_read, mem_write, out, 1 each: memory requests.
- run, out, 1: high unless halted or faulted.
- illegal_op, out, 1: one-cycle pulse on an undecodable opcode.
- fault, out, 1: sticky memory-timeout flag.

Behaviour:
- Bus codes:
  - BUS_REG = 00000, register-file output at addr_out.
  - BUS_PC = 10100.
  - BUS_IR = 10101.
  - BUS_MDR = 10110.
  - BUS_ZLO = 10111.
  - BUS_C = 11000, sign-extended C.
  - BUS_NONE = 11111.
- Opcodes:
  - LD = 00000, ST = 00010.
  - ADD = 00011, SUB = 00100, AND = 00101, OR = 00110.
  - ADDI = 01100.
  - NOP = 11010, HALT = 11011.
  - Anything else is illegal.
- Reset (any state, any cycle): state = T0, every strobe = 0, reg_out_select = BUS_NONE, addresses = 0, alu_op = 00, run = 1, fault = 0. An in-flight memory request is dropped the same cycle.
- Idle outputs: any strobe not listed for a state is 0; reg_out_select = BUS_NONE.
- Fetch:
  - T0: if stop = 1, hold T0 with all strobes 0. Else PC out, mar_in, inc_pc, then go to T1.
  - T1: mem_read = 1, mdr_rd = 1, mdr_in = 1. Hold T1 while mem_ready = 0. When mem_ready = 1, go to T2.
  - T2: MDR out, ir_in, then go to T3.
- T3 (decode plus first step):
  - ALU, ADDI, LD, ST: BUS_REG with addr_out = Rb, y_in, then go to T4.
  - NOP: go to T0.
  - HALT: go to HLT.
  - Illegal: pulse illegal_op, then go to T0.
- T4:
  - ALU: BUS_REG with addr_out = Rc, alu_op per opcode, z_in.
  - ADDI, LD, ST: BUS_C, alu_op = ADD, z_in.
- T5:
  - ALU, ADDI: BUS_ZLO, load = 1, addr_in = Ra, then go to T0.
  - LD, ST: BUS_ZLO, mar_in, then go to T6.
- T6:
  - LD: mem_read, mdr_rd = 1, mdr_in. Wait for mem_ready, then go to T7.
  - ST: BUS_REG with addr_out = Ra, mdr_rd = 0, mdr_in, then go to T7.
- T7:
  - LD: BUS_MDR, load = 1, addr_in = Ra, then go to T0.
  - ST: mem_write = 1. Wait for mem_ready, then go to T0.
- Wait counter:
  - Clears on entry to each memory-wait state and increments each cycle mem_ready = 0.
  - If MAX_WAIT ≠ 0 and the count reaches MAX_WAIT with mem_ready still 0: drop the request, set fault, go to HLT.
- mem_ready:
  - Sampled only in a memory-wait state; ignored elsewhere.
  - mem_ready = 1 on the first cycle of a wait state completes it with zero wait.
- HLT: all strobes 0, run = 0. Only reset exits.
- stop:
  - Honoured only in T0; a mid-instruction stop completes the instruction first.
  - stop and reset together: reset wins.
- Instruction latency with zero-wait memory:
  - ALU/ADDI: 6 cycles.
  - LD/ST: 8 cycles.
  - NOP/illegal: 4 cycles.
  - Each wait cycle adds 1.

Decomposition:
- Package mini_src_pkg: bus-select codes, opcode constants, alu_op encodings, state enum (T0..T7, HLT).
- Sub-module mini_src_decoder: combinational opcode → instruction class (ALU / IMM / LD / ST / NOP / HALT / ILLEGAL) plus alu_op. The FSM and wait counter stay in the top.

Test Plan:
- ADD: ir = 0x1A900000 (ADD, Ra = 5, Rb = 2, Rc = 0), mem_ready tied high.
  - T0 PC out / mar_in / inc_pc, T1 mem_read, T2 ir_in.
  - T3 addr_out = 2 with y_in, T4 addr_out = 0 with alu_op = 00 and z_in, T5 BUS_ZLO with load and addr_in = 5.
  - Back in T0 on cycle 7.
- LD: ir = LD, Ra = 3, Rb = 1, C = 0x00010; mem_ready low 3 cycles in T6.
  - T6 holds 4 cycles with mem_read high.
  - T7 BUS_MDR, load, addr_in = 3.
  - Total 11 cycles.
- ST with mem_ready low 20 cycles, MAX_WAIT = 15:
  - mem_write drops after 15 wait cycles.
  - fault = 1, run = 0, FSM in HLT.
  - Reset clears fault; next cycle is T0.
- Illegal opcode 11111: illegal_op high exactly 1 cycle in T3, no load/z_in, then T0.
- HALT then NOP stream: run = 0 after T3, outputs frozen at 0 for 50 cycles; reset resumes fetch.
- Reset asserted in T5 of ADD: load never pulses; next cycle is T0 with all strobes 0 and reg_out_select = 11111. stop = 1 at T0 holds T0 with no strobes until released.
